tt_um_audio_player: RTL and testbench



---
 rtl/tt_um_audio_player_pkg.sv | 36 +++
 rtl/tt_um_audio_player_tone_gen.sv | 37 +++
 rtl/tt_um_audio_player.sv | 121 ++++++++++++
 tb/tb_tt_um_audio_player.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_audio_player_pkg.sv
// Shared definitions for the melody player: FSM states, note table and
// the bit layout of the uo_out status/audio port.
package tt_um_audio_player_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int ROM_W     = 13;
   localparam int NUM_NOTES = 16;

   // Half-period of each note in clock cycles at 3.125 MHz; 0 marks a rest.
   // C4 up to C5, one rest, then back down to D4.
   localparam logic [ROM_W-1:0] NOTE_ROM [NUM_NOTES] = '{
      13'd5972, 13'd5321, 13'd4740, 13'd4474,
      13'd3986, 13'd3551, 13'd3164, 13'd2986,
      13'd0,    13'd2986, 13'd3164, 13'd3551,
      13'd3986, 13'd4474, 13'd4740, 13'd5321
   };

   // uo_out bit positions
   localparam int UO_AUDIO   = 0;
   localparam int UO_PLAYING = 1;
   localparam int UO_DONE    = 2;
   localparam int UO_IDX_LSB = 3;
   localparam int UO_IDX_MSB = 6;
   localparam int UO_REST    = 7;

   // Half-period lookup for a note index.
   function automatic logic [ROM_W-1:0] note_half_period(input logic [3:0] idx);
      return NOTE_ROM[idx];
   endfunction

endpackage

// File: rtl/tt_um_audio_player_tone_gen.sv
// Square-wave generator: counts half_period cycles and toggles audio.
// A zero half-period (rest) or an active clear forces silence and restarts
// the count so every note begins from a clean low phase.
module tt_um_audio_player_tone_gen
   import tt_um_audio_player_pkg::*;
#(
   parameter int HP_W = 13
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic            clear,
   input  logic [HP_W-1:0] half_period,
   output logic            audio
);

   logic [HP_W-1:0] count;

   // Half-period counter and audio toggle flip-flop, held while ena=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         audio <= 1'b0;
      end else if (ena) begin
         if (clear || (half_period == '0)) begin
            count <= '0;
            audio <= 1'b0;
         end else if (count == (half_period - 1'b1)) begin
            count <= '0;
            audio <= ~audio;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tt_um_audio_player.sv
// Tiny-Tapeout melody player top: steps through a 16-note table on a play
// request, drives a square wave per note and reports playback status.
module tt_um_audio_player
   import tt_um_audio_player_pkg::*;
#(
   parameter int NOTE_LEN = 31250,
   parameter int HP_W     = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int              DUR_W    = $clog2(NOTE_LEN);
   localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_LEN - 1);

   state_t           state;
   logic [3:0]       idx;
   logic [DUR_W-1:0] dur;

   logic             play;
   logic             loop;
   logic             in_play;
   logic             note_end;
   logic             tone_clear;
   logic [ROM_W-1:0] rom_hp;
   logic [HP_W-1:0]  half_period;
   logic             audio;
   logic             unused_ok;

   assign play        = ui_in[0];
   assign loop        = ui_in[1];
   assign in_play     = (state == ST_PLAY);
   assign note_end    = (dur == DUR_LAST);
   assign rom_hp      = note_half_period(idx);
   assign half_period = HP_W'(rom_hp);

   // The tone keeps running only while a note is actually sounding; any stop,
   // note boundary or non-PLAY state restarts it silent.
   assign tone_clear  = !(in_play && play && !note_end);

   assign unused_ok   = &{1'b0, ui_in[7:2], uio_in};

   // Playback FSM with note index and per-note duration counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         dur   <= '0;
      end else if (ena) begin
         case (state)
            ST_IDLE: begin
               idx <= '0;
               dur <= '0;
               if (play) state <= ST_PLAY;
            end
            ST_PLAY: begin
               if (!play) begin
                  state <= ST_IDLE;
                  idx   <= '0;
                  dur   <= '0;
               end else if (note_end) begin
                  dur <= '0;
                  if (idx != 4'd15) begin
                     idx <= idx + 4'd1;
                  end else if (loop) begin
                     idx <= '0;
                  end else begin
                     state <= ST_DONE;
                  end
               end else begin
                  dur <= dur + 1'b1;
               end
            end
            ST_DONE: begin
               dur <= '0;
               // A held play does not restart; play must drop first.
               if (!play) begin
                  state <= ST_IDLE;
                  idx   <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               idx   <= '0;
               dur   <= '0;
            end
         endcase
      end
   end

   tt_um_audio_player_tone_gen #(
      .HP_W(HP_W)
   ) u_tone (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .clear(tone_clear),
      .half_period(half_period),
      .audio(audio)
   );

   // Output decode from registered state only.
   always_comb begin
      uo_out                          = '0;
      uo_out[UO_AUDIO]                = audio;
      uo_out[UO_PLAYING]              = in_play;
      uo_out[UO_DONE]                 = (state == ST_DONE);
      uo_out[UO_IDX_MSB:UO_IDX_LSB]   = idx;
      uo_out[UO_REST]                 = in_play && (rom_hp == '0);
   end

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_audio_player.sv
// Self-checking bench for the melody player: a short-note instance checked
// against a time-based reference model, and a full-length instance for tone timing.
module tb_tt_um_audio_player;

   localparam int NL  = 16;
   localparam int NLL = 31250;
   localparam int REF_HP [16] = '{5972, 5321, 4740, 4474, 3986, 3551, 3164, 2986,
                                  0, 2986, 3164, 3551, 3986, 4474, 4740, 5321};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic [7:0] uo_out_l, uio_out_l, uio_oe_l;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: 0 idle, 1 play, 2 done; m_el = enabled PLAY edges since entry.
   int m_st = 0;
   int m_el = 0;

   always #160 clk = ~clk;

   tt_um_audio_player #(.NOTE_LEN(NL)) dut (
      .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   tt_um_audio_player #(.NOTE_LEN(NLL)) dut_long (
      .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out_l), .uio_out(uio_out_l), .uio_oe(uio_oe_l)
   );

   // Behavioural model of the short-note instance, by elapsed time in PLAY.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = 0;
         m_el = 0;
      end else if (ena) begin
         if (m_st == 0) begin
            if (ui_in[0]) begin
               m_st = 1;
               m_el = 0;
            end
         end else if (m_st == 1) begin
            if (!ui_in[0]) begin
               m_st = 0;
            end else begin
               m_el = m_el + 1;
               if ((m_el % NL == 0) && ((m_el / NL) % 16 == 0) && !ui_in[1]) m_st = 2;
            end
         end else if (!ui_in[0]) begin
            m_st = 0;
         end
      end
   end

   function automatic logic [7:0] exp_uo(input int st, input int el, input int nl);
      int n, k, hp;
      logic a;
      if (st == 0) return 8'h00;
      if (st == 2) return 8'h7C;
      n  = (el / nl) % 16;
      k  = el % nl;
      hp = REF_HP[n];
      a  = (hp != 0) && (((k / hp) % 2) == 1);
      return {hp == 0, n[3:0], 1'b0, 1'b1, a};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      ena   = 1'b1;
      ui_in = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst   = 1'b1;
      ui_in = 8'h00;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({uo_out, uio_out, uio_oe} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got uo=%h uio_out=%h uio_oe=%h want 00 00 00", uo_out, uio_out, uio_oe);
      end
      n_tests++;
      if ({uo_out_l, uio_out_l, uio_oe_l} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_outputs_long got uo=%h uio_out=%h uio_oe=%h want 00 00 00", uo_out_l, uio_out_l, uio_oe_l);
      end
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         n_tests++;
         if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_quiet cyc=%0d got %h want 00", c, uo_out);
         end
      end
   endtask

   task automatic test_tone();
      int el;
      do_reset();
      ui_in = 8'h01;
      @(negedge clk);
      el = 0;
      n_tests++;
      if (uo_out_l !== 8'h02) begin
         n_fail++;
         $display("FAIL tone_start got %h want 02", uo_out_l);
      end
      for (int c = 0; c < 12000; c++) begin
         n_tests++;
         if (uo_out_l !== exp_uo(1, el, NLL)) begin
            n_fail++;
            $display("FAIL tone cyc=%0d el=%0d got %h want %h", c, el, uo_out_l, exp_uo(1, el, NLL));
         end
         // Freeze just before the first toggle; the toggle must land 10 cycles late.
         ena = (c >= 5960 && c < 5970) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (ena) el++;
      end
      ena = 1'b1;
   endtask

   task automatic test_melody();
      do_reset();
      ui_in = 8'h01;
      @(negedge clk);
      n_tests++;
      if (uo_out[1] !== 1'b1 || uo_out[6:3] !== 4'd0) begin
         n_fail++;
         $display("FAIL melody_start got %h want playing=1 idx=0", uo_out);
      end
      for (int c = 0; c < 270; c++) begin
         n_tests++;
         if (uo_out !== exp_uo(m_st, m_el, NL)) begin
            n_fail++;
            $display("FAIL melody cyc=%0d got %h want %h", c, uo_out, exp_uo(m_st, m_el, NL));
         end
         @(negedge clk);
      end
      n_tests++;
      if (uo_out !== 8'h7C) begin
         n_fail++;
         $display("FAIL melody_done got %h want 7c", uo_out);
      end
      ui_in = 8'h00;
      @(negedge clk);
      n_tests++;
      if (uo_out !== 8'h00) begin
         n_fail++;
         $display("FAIL done_to_idle got %h want 00", uo_out);
      end
   endtask

   task automatic test_loop();
      do_reset();
      ui_in = 8'h03;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         n_tests++;
         if (uo_out !== exp_uo(m_st, m_el, NL) || uo_out[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL loop cyc=%0d got %h want %h", c, uo_out, exp_uo(m_st, m_el, NL));
         end
      end
      ui_in = 8'h00;
   endtask

   task automatic test_stop_freeze();
      do_reset();
      ui_in = 8'h01;
      repeat (40) @(negedge clk);
      ena = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_tests++;
         if (uo_out !== exp_uo(m_st, m_el, NL)) begin
            n_fail++;
            $display("FAIL freeze cyc=%0d got %h want %h", c, uo_out, exp_uo(m_st, m_el, NL));
         end
      end
      ena = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         n_tests++;
         if (uo_out !== exp_uo(m_st, m_el, NL)) begin
            n_fail++;
            $display("FAIL resume cyc=%0d got %h want %h", c, uo_out, exp_uo(m_st, m_el, NL));
         end
      end
      ui_in = 8'h00;
      @(negedge clk);
      n_tests++;
      if (uo_out !== 8'h00) begin
         n_fail++;
         $display("FAIL stop got %h want 00", uo_out);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         ena    = ($urandom_range(0, 7) != 0);
         uio_in = 8'($urandom);
         ui_in  = 8'($urandom);
         ui_in[0] = ($urandom_range(0, 511) != 0);
         @(negedge clk);
         n_tests++;
         if (uo_out !== exp_uo(m_st, m_el, NL) || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            n_fail++;
            $display("FAIL random cyc=%0d got %h want %h", c, uo_out, exp_uo(m_st, m_el, NL));
         end
      end
      ena   = 1'b1;
      ui_in = 8'h00;
   endtask

   task automatic test_async_reset();
      do_reset();
      ui_in = 8'h01;
      repeat (50) @(negedge clk);
      #20 rst = 1'b1;
      #1;
      n_tests++;
      if (uo_out !== 8'h00 || uo_out_l !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset got %h/%h want 00/00", uo_out, uo_out_l);
      end
      ui_in = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (uo_out !== 8'h00) begin
         n_fail++;
         $display("FAIL after_async_reset got %h want 00", uo_out);
      end
   endtask

   initial begin
      test_reset();
      test_melody();
      test_loop();
      test_stop_freeze();
      test_tone();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
